// File: rtl/boot_pkg.sv
// Shared constants for the instruction-memory boot loader: FSM encoding and
// stream framing sizes.
package boot_pkg;

    typedef logic [2:0] boot_state_t;

    localparam boot_state_t HDR_HI  = 3'd0;
    localparam boot_state_t HDR_LO  = 3'd1;
    localparam boot_state_t PAYLOAD = 3'd2;
    localparam boot_state_t CHECK   = 3'd3;
    localparam boot_state_t DONE    = 3'd4;
    localparam boot_state_t ERR     = 3'd5;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int CKSUM_BYTES    = 1;

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word assembler. Presents the completed word combinationally
// alongside a one-cycle word_valid strobe on the byte that finishes it.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);
    import boot_pkg::*;

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0] byte_cnt;
    logic [23:0]      shift_reg;

    // Only the first three bytes need storage; the fourth is taken straight off the bus.
    assign word       = {shift_reg, byte_in};
    assign word_valid = shift_en && (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            byte_cnt  <= '0;
            shift_reg <= '0;
        end else if (shift_en) begin
            byte_cnt  <= byte_cnt + CNT_W'(1);
            shift_reg <= {shift_reg[15:0], byte_in};
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed, XOR-checksummed program image into instruction
// memory and releases the core from reset only after a valid image.
module imem_boot_loader #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        error
);
    import boot_pkg::*;

    localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

    boot_state_t     state;
    boot_state_t     state_nx;
    logic [7:0]      n_hi;
    logic [15:0]     n_words;
    logic [ADDR_W:0] word_idx;
    logic [7:0]      cksum;

    logic        accept;
    logic        payload_shift;
    logic [15:0] hdr_n;
    logic        last_word;
    logic [31:0] word;
    logic        word_valid;

    assign accept        = rx_valid && rx_ready;
    assign payload_shift = accept && (state == PAYLOAD);
    assign hdr_n         = {n_hi, rx_data};
    assign last_word     = (17'(word_idx) + 17'd1) == {1'b0, n_words};

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == HDR_HI),
        .shift_en   (payload_shift),
        .byte_in    (rx_data),
        .word       (word),
        .word_valid (word_valid)
    );

    // NOTE: state_nx gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        if (accept) begin
            case (state)
                HDR_HI:  state_nx = HDR_LO;
                HDR_LO: begin
                    if ({1'b0, hdr_n} > CAPACITY) state_nx = ERR;
                    else if (hdr_n == 16'd0)      state_nx = CHECK;
                    else                          state_nx = PAYLOAD;
                end
                PAYLOAD: if (word_valid && last_word) state_nx = CHECK;
                CHECK:   state_nx = (rx_data == cksum) ? DONE : ERR;
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= HDR_HI;
            n_hi       <= '0;
            n_words    <= '0;
            word_idx   <= '0;
            cksum      <= '0;
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state    <= state_nx;
            // Outputs are registered off the next state so they line up with it.
            rx_ready <= (state_nx != DONE) && (state_nx != ERR);
            done     <= (state_nx == DONE);
            core_rst <= (state_nx == DONE);
            error    <= (state_nx == ERR);
            imem_we  <= word_valid;

            if (accept && state == HDR_HI) n_hi    <= rx_data;
            if (accept && state == HDR_LO) n_words <= hdr_n;
            if (payload_shift)             cksum   <= cksum ^ rx_data;

            if (word_valid) begin
                imem_addr  <= 32'({word_idx, 2'b00});
                imem_wdata <= word;
                word_idx   <= word_idx + {{ADDR_W{1'b0}}, 1'b1};
            end
        end
    end

endmodule
